// File: rtl/icache_pkg.sv
// icache_pkg: shared types and helpers for the direct-mapped instruction cache.
// Holds the fill FSM state enum, address field width helpers and line-base math.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } fill_state_t;

    localparam int ADDR_W = 32;
    localparam int BYTE_W = 2;

    function automatic int off_bits(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_bits(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_bits(input int lines, input int words);
        return ADDR_W - BYTE_W - $clog2(words) - $clog2(lines);
    endfunction

    // Byte address of the first word of the line holding addr.
    function automatic logic [31:0] line_base(
        input logic [31:0] addr,
        input int          words
    );
        logic [31:0] mask;
        mask = 32'(words * 4) - 32'd1;
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage for the instruction cache.
// Ports: clk, reset_n (async clear of valid bits); rd_* combinational lookup;
// inv_* clears one valid bit; word_we writes one data word; tag_we writes tag+valid.
module icache_array
    import icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4,
    parameter int OFF_W = off_bits(WORDS),
    parameter int IDX_W = idx_bits(LINES),
    parameter int TAG_W = tag_bits(LINES, WORDS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [IDX_W-1:0] rd_index,
    input  logic [OFF_W-1:0] rd_offset,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             inv_en,
    input  logic [IDX_W-1:0] inv_index,
    input  logic             word_we,
    input  logic [IDX_W-1:0] wr_index,
    input  logic [OFF_W-1:0] wr_offset,
    input  logic [31:0]      wr_data,
    input  logic             tag_we,
    input  logic [TAG_W-1:0] tag_data
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [31:0]      data_mem [LINES][WORDS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else begin
            if (inv_en) begin
                valid_q[inv_index] <= 1'b0;
            end
            if (tag_we) begin
                valid_q[wr_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (word_we) begin
            data_mem[wr_index][wr_offset] <= wr_data;
        end
        if (tag_we) begin
            tag_mem[wr_index] <= tag_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index][rd_offset];

endmodule

// File: rtl/instr_cache.sv
// instr_cache: direct-mapped read-only I-cache with line fill FSM and hit/miss counters.
// Ports: cpu_addr/cpu_instr/cpu_hold to the core; mem_addr/mem_data/mem_oe_n/mem_hold
// to instruction RAM; hit_count/miss_count saturating statistics.
module instr_cache
    import icache_pkg::*;
#(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_instr,
    output logic        cpu_hold,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic        mem_oe_n,
    input  logic        mem_hold,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int OFF_W   = off_bits(WORDS);
    localparam int IDX_W   = idx_bits(LINES);
    localparam int TAG_W   = tag_bits(LINES, WORDS);
    localparam int IDX_LSB = BYTE_W + OFF_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;

    fill_state_t state_q;
    fill_state_t state_d;

    logic [OFF_W-1:0] cnt_q;
    logic [31:0]      base_q;

    logic [OFF_W-1:0] cpu_off;
    logic [IDX_W-1:0] cpu_idx;
    logic [TAG_W-1:0] cpu_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             lookup_hit;
    logic             last_word;

    logic inv_en;
    logic word_we;
    logic tag_we;

    assign cpu_off  = cpu_addr[BYTE_W +: OFF_W];
    assign cpu_idx  = cpu_addr[IDX_LSB +: IDX_W];
    assign cpu_tag  = cpu_addr[TAG_LSB +: TAG_W];
    assign fill_idx = base_q[IDX_LSB +: IDX_W];
    assign fill_tag = base_q[TAG_LSB +: TAG_W];

    assign lookup_hit = rd_valid && (rd_tag == cpu_tag);
    assign last_word  = (cnt_q == '1);

    icache_array #(
        .LINES (LINES),
        .WORDS (WORDS),
        .OFF_W (OFF_W),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_index  (cpu_idx),
        .rd_offset (cpu_off),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .inv_en    (inv_en),
        .inv_index (cpu_idx),
        .word_we   (word_we),
        .wr_index  (fill_idx),
        .wr_offset (cnt_q),
        .wr_data   (mem_data),
        .tag_we    (tag_we),
        .tag_data  (fill_tag)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        inv_en  = 1'b0;
        word_we = 1'b0;
        tag_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!lookup_hit) begin
                    inv_en  = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!mem_hold) begin
                    word_we = 1'b1;
                    state_d = last_word ? DONE : REQ;
                end
            end
            DONE: begin
                tag_we  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            base_q     <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (inv_en) begin
                base_q <= line_base(cpu_addr, WORDS);
                cnt_q  <= '0;
            end
            if (word_we && !last_word) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == IDLE && lookup_hit && hit_count != '1) begin
                hit_count <= hit_count + 32'd1;
            end
            if (inv_en && miss_count != '1) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

    // Base is offset-aligned, so OR-ing the word offset equals base + 4*cnt.
    assign mem_addr  = base_q | 32'({cnt_q, 2'b00});
    assign mem_oe_n  = !(state_q == REQ || state_q == WAIT);
    assign cpu_instr = rd_data;
    assign cpu_hold  = reset_n && ((state_q != IDLE) || !lookup_hit);

endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: self-checking bench for instr_cache with a RAM model,
// a directed vector table, randomized fetches and reset/address-change sequences.
module tb_instr_cache;

    localparam int LINES = 16;
    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] cpu_addr = 32'h0040_0000;
    logic [31:0] cpu_instr;
    logic        cpu_hold;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_oe_n;
    logic        mem_hold = 1'b0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    always #5 clk = ~clk;

    instr_cache #(
        .LINES (LINES),
        .WORDS (WORDS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_addr   (cpu_addr),
        .cpu_instr  (cpu_instr),
        .cpu_hold   (cpu_hold),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_oe_n   (mem_oe_n),
        .mem_hold   (mem_hold),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return (a >> 2) * 32'h9E37_79B1 + 32'h0BAD_F00D;
    endfunction

    assign mem_data = ram_word(mem_addr);

    // RAM: each access starts on the first edge with oe_n low, then holds for ram_h cycles.
    int          ram_h = 16;
    logic        ram_act = 1'b0;
    int          ram_rem = 0;
    logic [31:0] acc_q[$];

    always @(posedge clk) begin
        if (mem_oe_n) begin
            ram_act  <= 1'b0;
            ram_rem  <= 0;
            mem_hold <= 1'b0;
        end else if (!ram_act) begin
            ram_act  <= 1'b1;
            ram_rem  <= ram_h;
            mem_hold <= (ram_h != 0);
            acc_q.push_back(mem_addr);
        end else if (ram_rem != 0) begin
            ram_rem  <= ram_rem - 1;
            mem_hold <= (ram_rem > 1);
        end else begin
            ram_act  <= 1'b0;
            mem_hold <= 1'b0;
        end
    end

    // Reference model: which tag each line holds, plus expected counter values.
    bit          mv[LINES];
    logic [31:0] mt[LINES];
    int          exp_hits = 0;
    int          exp_miss = 0;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / (WORDS * 4)) % LINES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a / (WORDS * 4 * LINES);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return mv[idx_of(a)] && (mt[idx_of(a)] == tag_of(a));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_counts(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_hits"}, hit_count, exp_hits);
        chk({tag, "_miss"}, miss_count, exp_miss);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_hold", cpu_hold, 0);
        chk("rst_oe_n", mem_oe_n, 1);
        chk("rst_addr", mem_addr, 0);
        chk("rst_hits", hit_count, 0);
        chk("rst_miss", miss_count, 0);
        for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
        exp_hits = 0;
        exp_miss = 0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    task automatic fetch(
        input logic [31:0] a,
        input int          h,
        input bit          exp_hit,
        input int          exp_stall
    );
        logic [31:0] base;
        bit          first;
        int          stall;
        int          n;
        @(negedge clk);
        ram_h = h;
        acc_q.delete();
        cpu_addr = a;
        #1;
        first = cpu_hold;
        stall = 0;
        n = 0;
        while (cpu_hold && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
            if (cpu_hold) stall++;
        end
        chk("fill_timeout", cpu_hold, 0);
        chk("first_hold", first, !exp_hit);
        base = a & ~32'(WORDS * 4 - 1);
        if (exp_hit) begin
            chk("hit_oe_n", mem_oe_n, 1);
            chk("hit_accesses", acc_q.size(), 0);
        end else begin
            chk("stall_cycles", stall, exp_stall);
            chk("fill_accesses", acc_q.size(), WORDS);
            for (int i = 0; i < WORDS && i < acc_q.size(); i++)
                chk("fill_addr", acc_q[i], base + 32'(4 * i));
            exp_miss++;
            mv[idx_of(a)] = 1'b1;
            mt[idx_of(a)] = tag_of(a);
        end
        chk("instr", cpu_instr, ram_word(a & ~32'h3));
        exp_hits++;
    endtask

    typedef struct {
        logic [31:0] addr;
        int          h;
        bit          hit;
        int          stall;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{32'h0040_0000, 16, 1'b0, 73};
        tbl[1] = '{32'h0040_0004, 16, 1'b1, 0};
        tbl[2] = '{32'h0040_0008, 16, 1'b1, 0};
        tbl[3] = '{32'h0040_000C, 16, 1'b1, 0};
        tbl[4] = '{32'h0040_0100, 16, 1'b0, 73};
        tbl[5] = '{32'h0040_0000, 16, 1'b0, 73};
        tbl[6] = '{32'h0040_0040, 0, 1'b0, 9};
        tbl[7] = '{32'h0040_0044, 0, 1'b1, 0};

        apply_reset();

        for (int i = 0; i < 8; i++) begin
            fetch(tbl[i].addr, tbl[i].h, tbl[i].hit, tbl[i].stall);
            if (i == 0 || i == 3 || i == 5 || i == 7) check_counts("tbl");
        end

        for (int k = 0; k < 40; k++) begin
            logic [31:0] a;
            int          h;
            a = 32'h0040_0000 + 32'($urandom_range(0, 1)) * 32'h400
                + (32'($urandom_range(0, 63)) << 2);
            h = int'($urandom_range(0, 3));
            fetch(a, h, model_hit(a), WORDS * (h + 2) + 1);
        end
        check_counts("rand");

        // Reset in the WAIT of word 2 aborts the fill; refetch needs a full fill.
        begin
            bit found;
            found = 1'b0;
            @(negedge clk);
            ram_h = 16;
            cpu_addr = 32'h0040_0880;
            for (int n = 0; n < 500 && !found; n++) begin
                @(negedge clk);
                #1;
                if (!mem_oe_n && mem_hold && mem_addr == 32'h0040_0888) found = 1'b1;
            end
            chk("reach_wait2", found, 1);
            apply_reset();
            fetch(32'h0040_0880, 16, 1'b0, 73);
            check_counts("rst_refill");
        end

        // Address change mid-fill: first line completes, then a second fill.
        apply_reset();
        begin
            logic [31:0] a0;
            logic [31:0] a1;
            bit          switched;
            int          stall;
            a0 = 32'h0040_0000;
            a1 = 32'h0040_0020;
            switched = 1'b0;
            stall = 0;
            @(negedge clk);
            ram_h = 0;
            acc_q.delete();
            cpu_addr = a0;
            #1;
            chk("chg_first_hold", cpu_hold, 1);
            for (int n = 0; n < 1000; n++) begin
                @(negedge clk);
                #1;
                if (!cpu_hold) break;
                stall++;
                if (!switched && !mem_oe_n && mem_addr == a0 + 32'd4) begin
                    cpu_addr = a1;
                    switched = 1'b1;
                end
            end
            chk("chg_timeout", cpu_hold, 0);
            chk("chg_stall", stall, 2 * (2 * WORDS + 1) + 1);
            chk("chg_accesses", acc_q.size(), 2 * WORDS);
            for (int i = 0; i < 2 * WORDS && i < acc_q.size(); i++)
                chk("chg_addr", acc_q[i],
                    (i < WORDS ? a0 : a1) + 32'(4 * (i % WORDS)));
            chk("chg_instr", cpu_instr, ram_word(a1));
            exp_miss += 2;
            exp_hits++;
            mv[idx_of(a0)] = 1'b1;
            mt[idx_of(a0)] = tag_of(a0);
            mv[idx_of(a1)] = 1'b1;
            mt[idx_of(a1)] = tag_of(a1);
            check_counts("chg");
            fetch(a0 + 32'd8, 0, 1'b1, 0);
            check_counts("chg_after");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_cache.md
# instr_cache

Direct-mapped, read-only instruction cache between the MIPS core's fetch port (`i_address` / `instruction` / `hold`) and the instruction RAM. Hits return the instruction in the same cycle with no stall. Misses stall the core through `cpu_hold` while the whole line is fetched from RAM, one word at a time, using the RAM's `hold` handshake. Hit and miss counters support the locality experiments run on the fib benchmarks.

## Interface
Parameters:
- `LINES`, 16 — number of cache lines; power of two, ≥2.
- `WORDS`, 4 — 32-bit words per line; power of two, ≥2.

Ports:
- `clk` in 1 — single clock, rising edge.
- `reset_n` in 1 — asynchronous, active-low reset.
- `cpu_addr` in 32 — fetch byte address; bits [1:0] are ignored.
- `cpu_instr` out 32 — instruction word; valid when `cpu_hold`=0.
- `cpu_hold` out 1 — stall request to the core.
- `mem_addr` out 32 — word-aligned RAM address.
- `mem_data` in 32 — RAM read data.
- `mem_oe_n` out 1 — RAM output enable, active low.
- `mem_hold` in 1 — RAM busy; high while an access is in progress.
- `hit_count` out 32 — saturating hit counter.
- `miss_count` out 32 — saturating miss counter.

## Operation
- Address split: offset = `cpu_addr[2 +: log2(WORDS)]`, index = next `log2(LINES)` bits, tag = remaining upper bits.
- Storage per line: valid bit, tag, and `WORDS` data words.
- Hit: state is IDLE, valid[index]=1 and tag matches.
  - `cpu_instr` = data[index][offset], combinational.
  - `cpu_hold` = 0.
- `cpu_hold` = 1 on a miss in IDLE, and in every non-IDLE state.
- FSM states:
  - IDLE, on a miss: latch the line base address (offset zeroed), clear the word counter, clear valid[index], go to REQ.
  - REQ: drive `mem_addr` = base + 4·counter and `mem_oe_n`=0. Always goes to WAIT after one cycle.
  - WAIT: keep the same `mem_addr` and `mem_oe_n`=0. When `mem_hold`=0, write `mem_data` into the word slot selected by the counter.
    - Last word: go to DONE.
    - Otherwise: increment the counter and go to REQ.
  - DONE: write the latched tag and set valid. Go to IDLE.
- In IDLE the lookup is re-evaluated against the current `cpu_addr`.
  - If the address changed during the fill and now misses, a new fill starts.
- A partially filled line never hits, because valid stays 0 until DONE.
- Counters:
  - `hit_count` increments on every IDLE hit cycle.
  - `miss_count` increments once per IDLE→REQ transition.
  - Both saturate at 0xFFFFFFFF.
- `mem_oe_n`=1 and `mem_addr` = last driven value while in IDLE and DONE.

## Timing
- Reset state: all valid bits 0, FSM in IDLE, counters 0, `mem_oe_n`=1, `mem_addr`=0.
- While `reset_n`=0, `cpu_hold` is forced to 0.
- Hit latency: 0 cycles, fully combinational from `cpu_addr`.
- Miss penalty: Σ over words of (1 REQ cycle + WAIT cycles) + 1 DONE cycle.
  - With `mem_hold` always 0: 2·WORDS+1 cycles of `cpu_hold`=1. The miss-detect cycle overlaps the first REQ transition.
  - With RAM hold of H cycles per access: WORDS·(1+H+1)+1 cycles.
- Reset asserted mid-fill aborts immediately: FSM returns to IDLE, all valid bits clear, the partial line is discarded.
- `mem_hold` is ignored in every state except WAIT.

## Structure
- Package `icache_pkg`:
  - FSM state enum (IDLE, REQ, WAIT, DONE).
  - Localparam helpers for offset, index and tag widths.
  - Line-base address function.
- One sub-module, `icache_array`:
  - Valid, tag and data storage.
  - Async-clear of the valid bits.
  - Combinational read port and synchronous word-write and tag-write ports.
  - FSM, counters and port muxing stay in `instr_cache`.

## Test plan
Defaults: LINES=16, WORDS=4; the RAM model holds for 16 cycles per access unless stated.
1. Cold miss at 0x00400000 → `cpu_hold` high for 4·18+1=73 cycles. `mem_addr` sequence 0x00400000, …04, …08, …0C. Then `cpu_instr` = RAM[0x00400000] with hold 0; `miss_count`=1.
2. After scenario 1, fetch 0x00400004, 0x00400008, 0x0040000C on consecutive cycles → `cpu_hold`=0 on every cycle, correct words returned, `hit_count` +3, `mem_oe_n` stays 1.
3. Conflict: fetch 0x00400100 (same index 0, different tag) → miss and refill; then 0x00400000 misses again; `miss_count`=3.
4. With `mem_hold` always 0, a miss at 0x00400040 → exactly 9 stall cycles; line 4 becomes valid.
5. Assert `reset_n`=0 during the WAIT of word 2 → `mem_oe_n`=1 and counters 0 at once. Refetching the same address after reset performs a full 4-word fill.
6. Change `cpu_addr` from 0x00400000 to 0x00400020 mid-fill → the first line completes. The next IDLE cycle misses and starts a fill at 0x00400020; `miss_count`=2.
